// File: rtl/pc_ctrl_pkg.sv
// pc_ctrl_pkg
// Shared types and constants for the program-counter sequencing controller.
//   pc_state_t           controller FSM states
//   TRAP_VECTOR_DEFAULT  PC loaded when a redirect target is misaligned
//   redirect_t           resolved EX-stage redirect (valid, isJump, tgt)
//   is_misaligned        word-alignment test on a target address
package pc_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        LSTALL = 2'd1,
        MWAIT  = 2'd2
    } pc_state_t;

    localparam logic [31:0] TRAP_VECTOR_DEFAULT = 32'h0000_0100;

    typedef struct packed {
        logic        valid;
        logic        isJump;
        logic [31:0] tgt;
    } redirect_t;

    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/pc_control_if.sv
// pc_control_if
// Bundles the controller's hazard/redirect inputs and its PC-register and
// pipeline-register controls.
//   master : the controller (consumes hazards, drives controls)
//   slave  : the core side (drives hazards, consumes controls)
interface pc_control_if;

    logic        imemReady;
    logic        loadUse;
    logic        branchTaken;
    logic [31:0] branchPC;
    logic [31:0] branchOffset;
    logic        jumpReg;
    logic [31:0] jumpTarget;
    logic        excAck;

    logic        hold;
    logic        branch;
    logic        bypass;
    logic [31:0] PCbranch;
    logic [31:0] PCcurrent;
    logic        stallIFID;
    logic        flushIFID;
    logic        flushIDEX;
    logic        excValid;
    logic [31:0] excAddr;

    modport master (
        input  imemReady, loadUse, branchTaken, branchPC, branchOffset,
               jumpReg, jumpTarget, excAck,
        output hold, branch, bypass, PCbranch, PCcurrent,
               stallIFID, flushIFID, flushIDEX, excValid, excAddr
    );

    modport slave (
        output imemReady, loadUse, branchTaken, branchPC, branchOffset,
               jumpReg, jumpTarget, excAck,
        input  hold, branch, bypass, PCbranch, PCcurrent,
               stallIFID, flushIFID, flushIDEX, excValid, excAddr
    );

endinterface

// File: rtl/redirect_resolve.sv
// redirect_resolve
// Combinational selection of the EX-stage redirect. JALR wins over a taken
// branch; the resolved target is flagged when it is not word aligned.
//   branchTaken/branchPC/branchOffset : conditional branch from EX
//   jumpReg/jumpTarget                : JALR from EX
//   redirect                          : valid, isJump, tgt
//   misaligned                        : valid redirect with tgt[1:0] != 0
import pc_ctrl_pkg::*;

module redirect_resolve (
    input  logic        branchTaken,
    input  logic [31:0] branchPC,
    input  logic [31:0] branchOffset,
    input  logic        jumpReg,
    input  logic [31:0] jumpTarget,
    output redirect_t   redirect,
    output logic        misaligned
);

    always_comb begin
        redirect = '0;
        if (jumpReg) begin
            redirect.valid  = 1'b1;
            redirect.isJump = 1'b1;
            redirect.tgt    = jumpTarget & ~32'd1;
        end else if (branchTaken) begin
            redirect.valid  = 1'b1;
            redirect.isJump = 1'b0;
            redirect.tgt    = branchPC + branchOffset;
        end
        misaligned = redirect.valid && is_misaligned(redirect.tgt);
    end

endmodule

// File: rtl/pc_control.sv
// pc_control
// Decides each cycle how the PC register advances and which pipeline
// registers stall or flush. Priority: trap > JALR > branch > load-use
// stall > instruction-memory wait > sequential advance.
//   Clock, Reset : rising-edge clock, synchronous active-high reset
//   bus          : pc_control_if.master (hazard inputs, PC/pipeline controls,
//                  registered exception record)
//
//   state  | meaning
//   RUN    | normal fetch; may start a load-use stall or memory wait
//   LSTALL | remaining load-use bubble cycles, counted down by cnt
//   MWAIT  | instruction memory not ready; PC held until it is
import pc_ctrl_pkg::*;

module pc_control #(
    parameter int unsigned LOAD_STALL  = 1,
    parameter logic [31:0] TRAP_VECTOR = TRAP_VECTOR_DEFAULT
) (
    input  logic         Clock,
    input  logic         Reset,
    pc_control_if.master bus
);

    // Counter holds LOAD_STALL-2 at most: the detection cycle and the final
    // LSTALL cycle (cnt==0) account for the other two bubbles.
    localparam int CNT_W = (LOAD_STALL > 2) ? $clog2(LOAD_STALL - 1) : 1;

    pc_state_t        state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             exc_valid_q;
    logic [31:0]      exc_addr_q;

    redirect_t        rd;
    logic             misaligned;
    logic             trap;

    logic             hold, branch, bypass;
    logic [31:0]      pc_branch, pc_current;
    logic             stall_ifid, flush_ifid, flush_idex;

    redirect_resolve u_redirect (
        .branchTaken  (bus.branchTaken),
        .branchPC     (bus.branchPC),
        .branchOffset (bus.branchOffset),
        .jumpReg      (bus.jumpReg),
        .jumpTarget   (bus.jumpTarget),
        .redirect     (rd),
        .misaligned   (misaligned)
    );

    assign trap = misaligned;

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        hold       = 1'b0;
        branch     = 1'b0;
        bypass     = 1'b0;
        pc_branch  = 32'd0;
        pc_current = 32'd0;
        stall_ifid = 1'b0;
        flush_ifid = 1'b0;
        flush_idex = 1'b0;

        if (rd.valid) begin
            // Any redirect abandons a pending stall or wait.
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
            state_n    = RUN;
            cnt_n      = '0;
            if (trap) begin
                bypass    = 1'b1;
                pc_branch = TRAP_VECTOR;
            end else if (rd.isJump) begin
                bypass    = 1'b1;
                pc_branch = rd.tgt;
            end else begin
                // PC register performs PCcurrent + PCbranch itself.
                branch     = 1'b1;
                pc_current = bus.branchPC;
                pc_branch  = bus.branchOffset;
            end
        end else begin
            case (state)
                RUN: begin
                    if (bus.loadUse) begin
                        hold       = 1'b1;
                        stall_ifid = 1'b1;
                        flush_idex = 1'b1;
                        if (LOAD_STALL > 1) begin
                            cnt_n   = CNT_W'(LOAD_STALL - 2);
                            state_n = LSTALL;
                        end
                    end else if (!bus.imemReady) begin
                        hold       = 1'b1;
                        stall_ifid = 1'b1;
                        flush_idex = 1'b1;
                        state_n    = MWAIT;
                    end
                end
                LSTALL: begin
                    hold       = 1'b1;
                    stall_ifid = 1'b1;
                    flush_idex = 1'b1;
                    if (cnt == '0) begin
                        state_n = bus.imemReady ? RUN : MWAIT;
                    end else begin
                        cnt_n = cnt - 1'b1;
                    end
                end
                MWAIT: begin
                    if (!bus.imemReady) begin
                        hold       = 1'b1;
                        stall_ifid = 1'b1;
                        flush_idex = 1'b1;
                    end else begin
                        state_n = RUN;
                    end
                end
                default: state_n = RUN;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state       <= RUN;
            cnt         <= '0;
            exc_valid_q <= 1'b0;
            exc_addr_q  <= 32'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            // A new trap beats an acknowledge in the same cycle; the first
            // faulting address is kept until the handler consumes it.
            if (trap) begin
                exc_valid_q <= 1'b1;
                if (!exc_valid_q) begin
                    exc_addr_q <= rd.tgt;
                end
            end else if (bus.excAck) begin
                exc_valid_q <= 1'b0;
            end
        end
    end

    // Reset forces every output low, including before the first reset edge.
    assign bus.hold      = !Reset && hold;
    assign bus.branch    = !Reset && branch;
    assign bus.bypass    = !Reset && bypass;
    assign bus.PCbranch  = Reset ? 32'd0 : pc_branch;
    assign bus.PCcurrent = Reset ? 32'd0 : pc_current;
    assign bus.stallIFID = !Reset && stall_ifid;
    assign bus.flushIFID = !Reset && flush_ifid;
    assign bus.flushIDEX = !Reset && flush_idex;
    assign bus.excValid  = !Reset && exc_valid_q;
    assign bus.excAddr   = Reset ? 32'd0 : exc_addr_q;

endmodule

// File: tb/tb_pc_control.sv
// tb_pc_control
// Directed bench for pc_control: a LOAD_STALL=2 instance drives a small PC
// register model; a LOAD_STALL=3 instance shares the inputs for the
// stall-length and reset-in-stall cases.
module tb_pc_control;

    logic Clock;
    logic Reset;
    logic Reset3;

    pc_control_if bus ();
    pc_control_if bus3 ();

    assign bus3.imemReady    = bus.imemReady;
    assign bus3.loadUse      = bus.loadUse;
    assign bus3.branchTaken  = bus.branchTaken;
    assign bus3.branchPC     = bus.branchPC;
    assign bus3.branchOffset = bus.branchOffset;
    assign bus3.jumpReg      = bus.jumpReg;
    assign bus3.jumpTarget   = bus.jumpTarget;
    assign bus3.excAck       = bus.excAck;

    pc_control #(.LOAD_STALL(2), .TRAP_VECTOR(32'h0000_0100)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus.master)
    );

    pc_control #(.LOAD_STALL(3), .TRAP_VECTOR(32'h0000_0100)) dut3 (
        .Clock (Clock),
        .Reset (Reset3),
        .bus   (bus3.master)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    // {hold, branch, bypass, stallIFID, flushIFID, flushIDEX}
    wire [5:0] ctl  = {bus.hold, bus.branch, bus.bypass,
                       bus.stallIFID, bus.flushIFID, bus.flushIDEX};
    wire [5:0] ctl3 = {bus3.hold, bus3.branch, bus3.bypass,
                       bus3.stallIFID, bus3.flushIFID, bus3.flushIDEX};

    localparam logic [5:0] C_IDLE  = 6'b000000;
    localparam logic [5:0] C_STALL = 6'b100101;
    localparam logic [5:0] C_BR    = 6'b010011;
    localparam logic [5:0] C_BYP   = 6'b001011;

    // External PC register model driven by the controller outputs.
    logic [31:0] pc;
    always @(posedge Clock) begin
        if (Reset)           pc <= 32'd0;
        else if (bus.hold)   pc <= pc;
        else if (bus.bypass) pc <= bus.PCbranch;
        else if (bus.branch) pc <= bus.PCcurrent + bus.PCbranch;
        else                 pc <= pc + 32'd4;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
    endtask

    initial begin
        Reset               = 1'b1;
        Reset3              = 1'b1;
        bus.imemReady       = 1'b1;
        bus.loadUse         = 1'b1;
        bus.branchTaken     = 1'b1;
        bus.branchPC        = 32'h20;
        bus.branchOffset    = 32'h6;
        bus.jumpReg         = 1'b0;
        bus.jumpTarget      = 32'd0;
        bus.excAck          = 1'b0;

        // Outputs forced low while reset is high, even with hazards present.
        #1;
        check_val("rst_ctl", 32'(ctl), 32'(C_IDLE));
        check_val("rst_pcbranch", bus.PCbranch, 32'd0);
        check_val("rst_pccurrent", bus.PCcurrent, 32'd0);
        tick();
        tick();
        check_val("rst_excvalid", 32'(bus.excValid), 32'd0);
        check_val("rst_excaddr", bus.excAddr, 32'd0);
        bus.loadUse     = 1'b0;
        bus.branchTaken = 1'b0;
        Reset           = 1'b0;
        Reset3          = 1'b0;

        // Idle run: PC 0,4,...,36.
        for (int i = 0; i < 10; i++) begin
            #1;
            check_val("idle_ctl", 32'(ctl), 32'(C_IDLE));
            check_val("idle_pc", pc, 32'(i * 4));
            tick();
        end

        // Load-use at PC=0x10, two bubble cycles.
        do_reset();
        repeat (4) tick();
        check_val("lu_start_pc", pc, 32'h10);
        bus.loadUse = 1'b1;
        #1;
        check_val("lu_c1_ctl", 32'(ctl), 32'(C_STALL));
        tick();
        bus.loadUse = 1'b0;
        #1;
        check_val("lu_c2_pc", pc, 32'h10);
        check_val("lu_c2_ctl", 32'(ctl), 32'(C_STALL));
        tick();
        check_val("lu_c3_pc", pc, 32'h10);
        check_val("lu_c3_ctl", 32'(ctl), 32'(C_IDLE));
        tick();
        check_val("lu_resume_pc", pc, 32'h14);

        // Backward branch, then JALR winning over a simultaneous branch.
        bus.branchTaken  = 1'b1;
        bus.branchPC     = 32'h20;
        bus.branchOffset = 32'hFFFF_FFF0;
        #1;
        check_val("br_ctl", 32'(ctl), 32'(C_BR));
        check_val("br_pccurrent", bus.PCcurrent, 32'h20);
        check_val("br_pcbranch", bus.PCbranch, 32'hFFFF_FFF0);
        tick();
        check_val("br_pc", pc, 32'h10);
        bus.jumpReg    = 1'b1;
        bus.jumpTarget = 32'h41;
        #1;
        check_val("jr_ctl", 32'(ctl), 32'(C_BYP));
        check_val("jr_pcbranch", bus.PCbranch, 32'h40);
        check_val("jr_pccurrent", bus.PCcurrent, 32'd0);
        tick();
        check_val("jr_pc", pc, 32'h40);
        bus.jumpReg = 1'b0;

        // Misaligned branch target 0x26 traps to 0x100.
        bus.branchPC     = 32'h20;
        bus.branchOffset = 32'h6;
        #1;
        check_val("trap_ctl", 32'(ctl), 32'(C_BYP));
        check_val("trap_pcbranch", bus.PCbranch, 32'h100);
        check_val("trap_excvalid_pre", 32'(bus.excValid), 32'd0);
        tick();
        check_val("trap_pc", pc, 32'h100);
        check_val("trap_excvalid", 32'(bus.excValid), 32'd1);
        check_val("trap_excaddr", bus.excAddr, 32'h26);
        // Second trap keeps the first address.
        bus.branchPC     = 32'h30;
        bus.branchOffset = 32'h1;
        tick();
        check_val("trap2_excaddr", bus.excAddr, 32'h26);
        // Misaligned JALR (0x43 & ~1 = 0x42) also traps.
        bus.branchTaken = 1'b0;
        bus.jumpReg     = 1'b1;
        bus.jumpTarget  = 32'h43;
        #1;
        check_val("trap_jr_pcbranch", bus.PCbranch, 32'h100);
        tick();
        check_val("trap_jr_excaddr", bus.excAddr, 32'h26);
        bus.jumpReg = 1'b0;
        bus.excAck  = 1'b1;
        #1;
        check_val("ack_pre_excvalid", 32'(bus.excValid), 32'd1);
        tick();
        check_val("ack_excvalid", 32'(bus.excValid), 32'd0);
        // New trap after clear captures new address; set beats acknowledge.
        bus.excAck      = 1'b0;
        bus.branchTaken = 1'b1;
        tick();
        check_val("retrap_excaddr", bus.excAddr, 32'h31);
        bus.excAck = 1'b1;
        tick();
        check_val("setwins_excvalid", 32'(bus.excValid), 32'd1);
        bus.branchTaken = 1'b0;
        tick();
        check_val("ack2_excvalid", 32'(bus.excValid), 32'd0);
        bus.excAck = 1'b0;

        // Memory back-pressure at PC=0x8 with a branch to 0x40 mid-wait.
        do_reset();
        repeat (2) tick();
        check_val("mw_start_pc", pc, 32'h8);
        bus.imemReady = 1'b0;
        #1;
        check_val("mw_c1_ctl", 32'(ctl), 32'(C_STALL));
        tick();
        check_val("mw_c1_pc", pc, 32'h8);
        bus.branchTaken  = 1'b1;
        bus.branchPC     = 32'h30;
        bus.branchOffset = 32'h10;
        #1;
        check_val("mw_c2_ctl", 32'(ctl), 32'(C_BR));
        tick();
        check_val("mw_c2_pc", pc, 32'h40);
        bus.branchTaken = 1'b0;
        #1;
        check_val("mw_c3_ctl", 32'(ctl), 32'(C_STALL));
        tick();
        check_val("mw_c3_pc", pc, 32'h40);
        bus.imemReady = 1'b1;
        #1;
        check_val("mw_ready_ctl", 32'(ctl), 32'(C_IDLE));
        tick();
        check_val("mw_ready_pc", pc, 32'h44);

        // LOAD_STALL=3 instance: three bubble cycles.
        Reset3 = 1'b1;
        tick();
        Reset3      = 1'b0;
        bus.loadUse = 1'b1;
        #1;
        check_val("ls3_c1_ctl", 32'(ctl3), 32'(C_STALL));
        tick();
        bus.loadUse = 1'b0;
        #1;
        check_val("ls3_c2_ctl", 32'(ctl3), 32'(C_STALL));
        tick();
        check_val("ls3_c3_ctl", 32'(ctl3), 32'(C_STALL));
        tick();
        check_val("ls3_c4_ctl", 32'(ctl3), 32'(C_IDLE));

        // Reset during the 2nd stall cycle returns to RUN.
        bus.loadUse = 1'b1;
        tick();
        bus.loadUse = 1'b0;
        #1;
        check_val("rs3_stall_ctl", 32'(ctl3), 32'(C_STALL));
        Reset3 = 1'b1;
        #1;
        check_val("rs3_rst_ctl", 32'(ctl3), 32'(C_IDLE));
        check_val("rs3_rst_excvalid", 32'(bus3.excValid), 32'd0);
        tick();
        Reset3 = 1'b0;
        #1;
        check_val("rs3_post1_ctl", 32'(ctl3), 32'(C_IDLE));
        tick();
        check_val("rs3_post2_ctl", 32'(ctl3), 32'(C_IDLE));
        check_val("rs3_excaddr", bus3.excAddr, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_control.md
# pc_control

Front-end sequencing controller for the pipelined core: it decides, every cycle, how the program counter register advances. It drives that register's `hold`, `branch`, `bypass`, `PCbranch` and `PCcurrent` controls and the IF/ID and ID/EX pipeline-register stall/flush strobes. It combines EX-stage redirects, ID-stage load-use hazards, instruction-memory back-pressure and misaligned-target traps, resolving them under a fixed priority.

## Interface
- `LOAD_STALL`, 1: bubble cycles inserted per load-use hazard (≥1).
- `TRAP_VECTOR`, 32'h0000_0100: PC loaded on a misaligned redirect target.
- `Clock`  in  1  rising-edge clock.
- `Reset`  in  1  synchronous, active-high reset.
- `imemReady`  in  1  instruction memory accepts the current fetch this cycle.
- `loadUse`  in  1  ID-stage load-use hazard detected.
- `branchTaken`  in  1  EX-stage conditional branch resolved taken.
- `branchPC`  in  32  PC of the branch in EX.
- `branchOffset`  in  32  sign-extended branch offset.
- `jumpReg`  in  1  EX-stage JALR resolved.
- `jumpTarget`  in  32  JALR target, before bit-0 clear.
- `excAck`  in  1  trap handler has consumed the exception record.
- `hold`, `branch`, `bypass`  out  1 each  PC register controls.
- `PCbranch`, `PCcurrent`  out  32 each  PC register operands.
- `stallIFID`  out  1  hold the IF/ID register.
- `flushIFID`, `flushIDEX`  out  1 each  zero (bubble) the pipeline register.
- `excValid`  out  1  misaligned-target exception pending (registered).
- `excAddr`  out  32  faulting target address (registered).

## Operation
- States: `RUN`, `LSTALL`, `MWAIT`. Only the state, a stall counter, `excValid` and `excAddr` are registered. All other outputs are combinational from the state and the inputs.
- Redirect target `tgt`:
  - JALR: `jumpTarget & ~1`.
  - Branch: `branchPC + branchOffset`, mod 2^32.
  - Misaligned when `tgt[1:0] != 0`.
- Per-cycle priority, applied in every state:
  1. **Trap**, a redirect with a misaligned `tgt`:
     - Outputs: `bypass`=1, `PCbranch`=`TRAP_VECTOR`, both flushes=1.
     - If `excValid`=0, set `excValid` and load `excAddr`=`tgt`.
     - Next state `RUN`.
  2. **JALR**:
     - Outputs: `bypass`=1, `PCbranch`=`tgt`, both flushes=1.
     - Next state `RUN`.
  3. **Branch**:
     - Outputs: `branch`=1, `PCcurrent`=`branchPC`, `PCbranch`=`branchOffset`, both flushes=1.
     - Next state `RUN`.
  4. **RUN with `loadUse`**:
     - Outputs: `hold`=1, `stallIFID`=1, `flushIDEX`=1.
     - If `LOAD_STALL`>1, load counter=`LOAD_STALL`-2 and go to `LSTALL`.
  5. **LSTALL**:
     - Same outputs as row 4. `loadUse` is ignored.
     - Counter decrements. At 0, go to `RUN`.
  6. **`imemReady`=0**, in `RUN`, or in `LSTALL` at its final cycle:
     - Outputs: `hold`=1, `stallIFID`=1, `flushIDEX`=1.
     - Next state `MWAIT`.
  7. **MWAIT**:
     - While `imemReady`=0: same outputs as row 6.
     - On the first cycle with `imemReady`=1: all controls 0 (PC+4), next state `RUN`.
  8. **Otherwise**: all controls 0, so the PC advances by 4.
- When both `jumpReg` and `branchTaken` are high, JALR wins.
- A redirect is applied even when `imemReady`=0; the new fetch restarts at the target.
- `excValid` clears on the edge where `excAck`=1, unless a new trap sets it in the same cycle. Set wins.
- `PCbranch` and `PCcurrent` are 0 whenever they are not in use.

## Timing
- A decision made in cycle n takes effect at the PC on the edge ending cycle n. Latency 0, and there is no redirect penalty beyond the flushed slots.
- Load-use stall: `hold` is high for exactly `LOAD_STALL` consecutive cycles, starting in the detection cycle.
- Reset (`Reset`=1 at an edge), including mid-stall or mid-wait:
  - Next state is `RUN`, counter 0, `excValid`=0, `excAddr`=0.
  - While `Reset`=1, every output is forced to 0.
- A redirect in `LSTALL` or `MWAIT` abandons the stall or wait that same cycle.

## Structure
- Package `pc_ctrl_pkg` holds:
  - `pc_state_t` enum {`RUN`, `LSTALL`, `MWAIT`}.
  - `TRAP_VECTOR_DEFAULT`.
  - A `redirect_t` struct (`valid`, `isJump`, `tgt`).
- One sub-module, `redirect_resolve`. It is purely combinational: it selects JALR/branch, computes `tgt` and flags misalignment.
- The FSM, counter and exception register live in `pc_control`.

## Test plan
- Idle run: `imemReady`=1, no hazards, 10 cycles → all controls 0 and the PC steps 0,4,8…36.
- Load-use with `LOAD_STALL`=2, `loadUse` pulsed 1 cycle at PC=0x10 → `hold`/`stallIFID`/`flushIDEX` high for 2 cycles, then the PC resumes at 0x14.
- Branch at `branchPC`=0x20, `branchOffset`=0xFFFF_FFF0 → `branch`=1, both flushes=1, next PC=0x10. With simultaneous `jumpReg`, `jumpTarget`=0x41 → `bypass`=1 and next PC=0x40 instead.
- Misaligned branch, `branchPC`=0x20, `branchOffset`=6:
  - Expect next PC=0x100, then `excValid`=1 with `excAddr`=0x26.
  - A second misaligned trap does not change `excAddr`.
  - `excAck` clears `excValid` one edge later.
- Memory back-pressure: `imemReady`=0 for 3 cycles at PC=0x8, with a branch to 0x40 in the 2nd cycle → PC=0x40 after that edge. `hold`=1 until `imemReady` returns, then PC=0x44.
- `Reset` asserted in `LSTALL` (`LOAD_STALL`=3, 2nd stall cycle) → all outputs 0 while asserted, then the `RUN` state and normal advance after release.
